spi_image_loader: RTL

- Producer side of the foreground SRAM wrapper's SPI pixel-write handshake.
- Parses a byte stream from the SPI slave into a rectangle header plus RGB565 pixels, and computes each pixel's screen coordinates.
- Buffers pixels in a small FIFO and presents them one at a time on spi_pixel_ready / spi_pixel_read.
- Asserts ready only while frozen, so live foreground reads are never starved.

---
 rtl/spi_image_loader_pkg.sv | 30 +++
 rtl/spi_image_loader_pixel_fifo.sv | 55 +++++
 rtl/spi_image_loader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/spi_image_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_image_loader_pkg
//  Description : Shared foreground types and constants for the SPI image path.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_image_loader_pkg;

    localparam int SRAM_DELAY   = 5;
    localparam int HEADER_BYTES = 8;
    localparam int FG_PRECISION = 11;

    typedef logic [15:0]                  rgb565_t;
    typedef logic signed [FG_PRECISION:0] coord_t;

    typedef struct packed {
        rgb565_t pixel;
        coord_t  x;
        coord_t  y;
    } pix_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_PIXELS = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_image_loader_pixel_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_fifo
//  Description : Synchronous FIFO with flush; a push is accepted while full
//                when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo
    import spi_image_loader_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(pix_entry_t)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr;
    logic [c_AW:0]    r_rd;
    logic             w_do_pop;
    logic             w_do_push;

    // Extra pointer MSB distinguishes full from empty.
    assign empty     = (r_wr == r_rd);
    assign full      = (r_wr[c_AW] != r_rd[c_AW]) && (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr[c_AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/spi_image_loader.sv
`default_nettype none
// ============================================================================
//  Module      : spi_image_loader
//  Description : Parses an SPI rectangle upload into clipped, coordinate-tagged
//                RGB565 pixels and hands them to the FG SRAM wrapper.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_image_loader
    import spi_image_loader_pkg::*;
#(
    parameter int X_RES      = 800,
    parameter int Y_RES      = 600,
    parameter int PRECISION  = FG_PRECISION,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frozen,
    input  logic                  frame_start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    output logic                  spi_pixel_ready,
    input  logic                  spi_pixel_read,
    output logic [15:0]           spi_pixel_in,
    output logic signed [PRECISION:0] spi_pixel_x,
    output logic signed [PRECISION:0] spi_pixel_y,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int                 c_COORD_W = PRECISION + 1;
    localparam int                 c_ENTRY_W = 16 + 2 * c_COORD_W;
    localparam logic signed [16:0] c_X_MAX   = 17'(X_RES - 1);
    localparam logic signed [16:0] c_Y_MAX   = 17'(Y_RES - 1);

    state_t                 r_state, w_state_next;
    logic [2:0]             r_hdr_cnt, w_hdr_idx;
    logic [55:0]            r_hdr;
    logic [63:0]            w_hdr_full;
    logic signed [16:0]     r_x0, r_xlast, r_cx, r_cy;
    logic signed [16:0]     w_x0_ext, w_y0_ext;
    logic [15:0]            r_h_m1, r_row;
    logic                   r_phase;
    logic [7:0]             r_hi;
    logic                   r_slot_valid, w_slot_valid_next;
    logic [c_ENTRY_W-1:0]   r_slot, w_entry, w_fifo_dout;
    logic                   r_ready, r_overflow;
    logic                   w_hdr_byte, w_hdr_last, w_hdr_zero;
    logic                   w_pix_byte, w_pix_valid, w_row_end, w_last_pix, w_in_range;
    logic                   w_push, w_pop, w_ack, w_fifo_full, w_fifo_empty;
    rgb565_t                w_pixel;

    // A byte arriving with frame_start is header byte 0 of the new transaction.
    assign w_hdr_byte  = byte_valid && (frame_start || r_state == ST_HEADER);
    assign w_hdr_idx   = frame_start ? 3'd0 : r_hdr_cnt;
    assign w_hdr_last  = w_hdr_byte && (w_hdr_idx == 3'(HEADER_BYTES - 1));
    assign w_hdr_full  = {r_hdr, byte_in};
    assign w_hdr_zero  = (w_hdr_full[31:16] == 16'd0) || (w_hdr_full[15:0] == 16'd0);
    assign w_x0_ext    = {w_hdr_full[63], w_hdr_full[63:48]};
    assign w_y0_ext    = {w_hdr_full[47], w_hdr_full[47:32]};

    assign w_pix_byte  = byte_valid && !frame_start && (r_state == ST_PIXELS);
    assign w_pix_valid = w_pix_byte && r_phase;
    assign w_pixel     = {r_hi, byte_in};
    assign w_row_end   = (r_cx == r_xlast);
    assign w_last_pix  = w_row_end && (r_row == r_h_m1);
    assign w_in_range  = (r_cx >= 17'sd0) && (r_cx <= c_X_MAX) &&
                         (r_cy >= 17'sd0) && (r_cy <= c_Y_MAX);
    assign w_entry     = {w_pixel, r_cx[c_COORD_W-1:0], r_cy[c_COORD_W-1:0]};

    assign w_push      = w_pix_valid && w_in_range;
    assign w_pop       = !r_slot_valid && !w_fifo_empty && !frame_start;
    // An ack is honoured even after ready fell: the wrapper already issued the write.
    assign w_ack       = spi_pixel_read && r_slot_valid;
    assign w_slot_valid_next = w_ack ? 1'b0 : (w_pop ? 1'b1 : r_slot_valid);

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (frame_start),
        .push  (w_push),
        .din   (w_entry),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (frame_start) begin
            w_state_next = ST_HEADER;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_next = ST_IDLE;
                ST_HEADER: if (w_hdr_last) w_state_next = w_hdr_zero ? ST_IDLE : ST_PIXELS;
                ST_PIXELS: if (w_pix_valid && w_last_pix) w_state_next = ST_DRAIN;
                ST_DRAIN:  if (w_fifo_empty && !r_slot_valid) w_state_next = ST_IDLE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr_cnt    <= '0;
            r_hdr        <= '0;
            r_x0         <= '0;
            r_xlast      <= '0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_h_m1       <= '0;
            r_row        <= '0;
            r_phase      <= 1'b0;
            r_hi         <= '0;
            r_slot_valid <= 1'b0;
            r_slot       <= '0;
            r_ready      <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_hdr_byte) begin
                r_hdr     <= w_hdr_full[55:0];
                r_hdr_cnt <= w_hdr_idx + 3'd1;
            end else if (frame_start) begin
                r_hdr_cnt <= '0;
            end

            if (w_hdr_last) begin
                r_x0    <= w_x0_ext;
                r_cx    <= w_x0_ext;
                r_cy    <= w_y0_ext;
                r_xlast <= w_x0_ext + $signed({1'b0, w_hdr_full[31:16]}) - 17'sd1;
                r_h_m1  <= w_hdr_full[15:0] - 16'd1;
                r_row   <= '0;
            end else if (w_pix_valid) begin
                if (w_row_end) begin
                    r_cx  <= r_x0;
                    r_cy  <= r_cy + 17'sd1;
                    r_row <= r_row + 16'd1;
                end else begin
                    r_cx  <= r_cx + 17'sd1;
                end
            end

            if (frame_start || w_hdr_last) begin
                r_phase <= 1'b0;
            end else if (w_pix_byte) begin
                r_phase <= ~r_phase;
                if (!r_phase) r_hi <= byte_in;
            end

            if (frame_start)
                r_overflow <= 1'b0;
            else if (w_push && w_fifo_full && !w_pop)
                r_overflow <= 1'b1;

            r_slot_valid <= w_slot_valid_next;
            if (w_pop) r_slot <= w_fifo_dout;
            r_ready      <= w_slot_valid_next && frozen;
        end
    end

    assign spi_pixel_ready = r_ready;
    assign spi_pixel_in    = r_slot[c_ENTRY_W-1 -: 16];
    assign spi_pixel_x     = r_slot[2*c_COORD_W-1 -: c_COORD_W];
    assign spi_pixel_y     = r_slot[c_COORD_W-1:0];
    assign busy            = (r_state != ST_IDLE);
    assign done            = (r_state == ST_DRAIN) && w_fifo_empty && !r_slot_valid;
    assign overflow        = r_overflow;

endmodule
`default_nettype wire
